// File: rtl/tt_um_count_checker.sv
// Receive-side sequence monitor for the 4-bit up-counter tile: locks onto a clean count run, flags/counts slips and wraps.
// Optional: define COUNT_CHECKER_AUTO_RESYNC_EN to make FAULT fall back to resync after one sample instead of holding.
module tt_um_count_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] OBS_MAX = {WIDTH{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t             state_q;
  logic [WIDTH-1:0]   prev_q;
  logic [2:0]         run_q;
  logic [ERR_W-1:0]   errCnt_q;
  logic               errSticky_q;
  logic               locked_q;
  logic               mismatch_q;
  logic               wrap_q;
  logic [7:0]         wrapCnt_q;

  logic [WIDTH-1:0]   obs;
  logic               clrObs;
  logic               errClr;
  logic [WIDTH-1:0]   expVal;
  logic               obsMatch;
  logic               wrapHit;
  logic               runDone;
  logic               unusedInputs;

  assign obs    = ui_in[WIDTH-1:0];
  assign clrObs = ui_in[4];
  assign errClr = ui_in[5];

  // A counter clear makes 0 the only valid next value, regardless of history.
  always_comb begin
    expVal   = clrObs ? '0 : prev_q + 1'b1;
    obsMatch = (obs == expVal);
    wrapHit  = obsMatch && !clrObs && (prev_q == OBS_MAX) && (obs == '0);
    runDone  = (int'(run_q) + 1) == LOCK_CNT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      prev_q      <= '0;
      run_q       <= '0;
      errCnt_q    <= '0;
      errSticky_q <= 1'b0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      wrap_q      <= 1'b0;
      wrapCnt_q   <= '0;
    end else if (!ena) begin
      mismatch_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      wrap_q     <= 1'b0;
      // err_clr wins over any compare this sample, so prev is left alone too.
      if (errClr) begin
        errCnt_q    <= '0;
        errSticky_q <= 1'b0;
        locked_q    <= 1'b0;
        run_q       <= '0;
        state_q     <= SYNC;
      end else begin
        prev_q <= obs;
        case (state_q)
          SYNC: begin
            run_q   <= '0;
            state_q <= ACQUIRE;
          end
          ACQUIRE: begin
            if (obsMatch) begin
              run_q <= run_q + 3'd1;
              if (runDone) begin
                locked_q <= 1'b1;
                state_q  <= LOCKED;
              end
            end else begin
              run_q <= '0;
            end
          end
          LOCKED: begin
            if (obsMatch) begin
              if (wrapHit) begin
                wrap_q    <= 1'b1;
                wrapCnt_q <= wrapCnt_q + 8'd1;
              end
            end else begin
              mismatch_q  <= 1'b1;
              errSticky_q <= 1'b1;
              locked_q    <= 1'b0;
              if (errCnt_q != ERR_MAX) begin
                errCnt_q <= errCnt_q + 1'b1;
              end
              state_q <= FAULT;
            end
          end
          FAULT: begin
`ifdef COUNT_CHECKER_AUTO_RESYNC_EN
            run_q   <= '0;
            state_q <= ACQUIRE;
`else
            state_q <= FAULT;
`endif
          end
          default: state_q <= SYNC;
        endcase
      end
    end
  end

  assign uo_out  = {4'(errCnt_q), wrap_q, mismatch_q, errSticky_q, locked_q};
  assign uio_out = wrapCnt_q;
  assign uio_oe  = 8'hFF;

  assign unusedInputs = ^{uio_in, ui_in[7:6], 1'b0};

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Self-checking bench for tt_um_count_checker: directed vector table, corner sequences, and randomized run
// against a behavioural model.
module tb_tt_um_count_checker;

  localparam int LOCK_CNT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  tt_um_count_checker #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .ERR_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=sync,1=acquire,2=locked,3=fault.
  int         mMode;
  int         mPrev;
  int         mRun;
  int         mErr;
  bit         mSticky, mLocked, mMis, mWrap;
  int         mWraps;

  function automatic void modelStep(bit r, bit e, logic [7:0] u);
    int obs, expv;
    bit clr, good;
    if (!r) begin
      mMode = 0; mPrev = 0; mRun = 0; mErr = 0;
      mSticky = 0; mLocked = 0; mMis = 0; mWrap = 0; mWraps = 0;
      return;
    end
    mMis = 0;
    mWrap = 0;
    if (!e) return;
    obs = int'(u[3:0]);
    clr = u[4];
    if (u[5]) begin
      mErr = 0; mSticky = 0; mLocked = 0; mMode = 0;
      return;
    end
    expv = clr ? 0 : (mPrev + 1) % 16;
    good = (obs == expv);
    if (mMode == 0) begin
      mRun = 0; mMode = 1;
    end else if (mMode == 1) begin
      if (good) begin
        mRun = mRun + 1;
        if (mRun == LOCK_CNT) begin mMode = 2; mLocked = 1; end
      end else mRun = 0;
    end else if (mMode == 2) begin
      if (good) begin
        if (mPrev == 15 && obs == 0 && !clr) begin
          mWrap = 1;
          mWraps = (mWraps + 1) % 256;
        end
      end else begin
        mMis = 1; mSticky = 1; mLocked = 0; mMode = 3;
        if (mErr < 15) mErr = mErr + 1;
      end
    end else begin
`ifdef COUNT_CHECKER_AUTO_RESYNC_EN
      mRun = 0; mMode = 1;
`endif
    end
    mPrev = obs;
  endfunction

  function automatic logic [7:0] modelUo();
    return {4'(mErr), mWrap, mMis, mSticky, mLocked};
  endfunction

  task automatic applyStimulus(input bit r, input bit e, input logic [7:0] u);
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = u;
    uio_in = 8'($urandom);
    modelStep(r, e, u);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expUo, input logic [7:0] expUio);
    checks++;
    if (uo_out !== expUo) begin
      errors++;
      $display("[TB] FAIL %s uo_out got %h want %h", name, uo_out, expUo);
    end
    checks++;
    if (uio_out !== expUio) begin
      errors++;
      $display("[TB] FAIL %s uio_out got %h want %h", name, uio_out, expUio);
    end
  endtask

  task automatic modelCheck(input string name, input bit r, input bit e, input logic [7:0] u);
    applyStimulus(r, e, u);
    checkOutput(name, modelUo(), 8'(mWraps));
  endtask

  task automatic goodStep(input string name);
    modelCheck(name, 1'b1, 1'b1, 8'((mPrev + 1) % 16));
  endtask

  typedef struct {
    bit         rstN;
    bit         en;
    logic [7:0] ui;
    logic [7:0] expUo;
    logic [7:0] expUio;
  } vec_t;

  vec_t vecs[$];

  function automatic void pushVec(bit r, bit e, logic [7:0] u, logic [7:0] eu, logic [7:0] eio);
    vec_t v;
    v.rstN = r; v.en = e; v.ui = u; v.expUo = eu; v.expUio = eio;
    vecs.push_back(v);
  endfunction

  initial begin
    int pulses;
    int k;
    logic [7:0] u;
    bit r, e;

    pushVec(0, 1, 8'h00, 8'h00, 8'h00);
    pushVec(1, 1, 8'h05, 8'h00, 8'h00);
    pushVec(1, 1, 8'h06, 8'h00, 8'h00);
    pushVec(1, 1, 8'h07, 8'h00, 8'h00);
    pushVec(1, 1, 8'h08, 8'h01, 8'h00);
    for (int v = 9; v <= 15; v++) pushVec(1, 1, 8'(v), 8'h01, 8'h00);
    pushVec(1, 1, 8'h00, 8'h09, 8'h01);
    pushVec(1, 0, 8'h55, 8'h01, 8'h01);
    pushVec(1, 1, 8'h01, 8'h01, 8'h01);
    for (int v = 2; v <= 7; v++) pushVec(1, 1, 8'(v), 8'h01, 8'h01);
    pushVec(1, 1, 8'h10, 8'h01, 8'h01);
    pushVec(1, 1, 8'h01, 8'h01, 8'h01);
    pushVec(1, 1, 8'h02, 8'h01, 8'h01);
    pushVec(1, 1, 8'h09, 8'h16, 8'h01);
    pushVec(1, 0, 8'h3F, 8'h12, 8'h01);
    pushVec(1, 1, 8'h0A, 8'h12, 8'h01);
    pushVec(1, 1, 8'h25, 8'h00, 8'h01);
    pushVec(1, 1, 8'h05, 8'h00, 8'h01);
    pushVec(1, 1, 8'h06, 8'h00, 8'h01);
    pushVec(1, 1, 8'h07, 8'h00, 8'h01);
    pushVec(1, 1, 8'h08, 8'h01, 8'h01);
    pushVec(1, 1, 8'h23, 8'h00, 8'h01);
    pushVec(1, 1, 8'h04, 8'h00, 8'h01);
    pushVec(1, 1, 8'h05, 8'h00, 8'h01);
    pushVec(1, 1, 8'h06, 8'h00, 8'h01);
    pushVec(1, 1, 8'h07, 8'h01, 8'h01);
    pushVec(1, 0, 8'hFF, 8'h01, 8'h01);
    pushVec(1, 0, 8'h3A, 8'h01, 8'h01);
    pushVec(1, 0, 8'h00, 8'h01, 8'h01);
    pushVec(1, 0, 8'hC5, 8'h01, 8'h01);
    pushVec(0, 1, 8'h09, 8'h00, 8'h00);

    $display("[TB] directed vector table, %0d entries", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].en, vecs[i].ui);
      checkOutput($sformatf("vec%0d", i), vecs[i].expUo, vecs[i].expUio);
    end

    checks++;
    if (uio_oe !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL uio_oe got %h want ff", uio_oe);
    end

    // Lock, then hold ena low with random inputs: levels must freeze.
    modelCheck("hold_rst", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) goodStep("hold_lock");
    for (int i = 0; i < 10; i++) begin
      modelCheck("hold_ena0", 1'b1, 1'b0, 8'($urandom));
      checks++;
      if (uo_out !== 8'h01) begin
        errors++;
        $display("[TB] FAIL hold_level uo_out got %h want 01", uo_out);
      end
    end

    // Sequence after a slip: resync behaviour depends on the build option.
    modelCheck("slip_rst", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) goodStep("slip_lock");
    modelCheck("slip_bad", 1'b1, 1'b1, 8'((mPrev + 7) % 16));
    for (int i = 0; i < 6; i++) goodStep("slip_after");
    checks++;
`ifdef COUNT_CHECKER_AUTO_RESYNC_EN
    if (uo_out[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL slip_relock locked got %b want 1", uo_out[0]);
    end
`else
    if (uo_out[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL slip_hold locked got %b want 0", uo_out[0]);
    end
`endif

`ifdef COUNT_CHECKER_AUTO_RESYNC_EN
    // Sixteen slips, each after a re-lock: counter saturates, every slip still pulses.
    modelCheck("sat_rst", 1'b0, 1'b1, 8'h00);
    pulses = 0;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 5; i++) goodStep("sat_lock");
      modelCheck("sat_bad", 1'b1, 1'b1, 8'((mPrev + 5) % 16));
      if (uo_out[2]) pulses++;
    end
    checks++;
    if (uo_out[7:4] !== 4'hF) begin
      errors++;
      $display("[TB] FAIL sat_errcnt got %h want f", uo_out[7:4]);
    end
    checks++;
    if (pulses != 16) begin
      errors++;
      $display("[TB] FAIL sat_pulses got %0d want 16", pulses);
    end
`endif

    // Randomized run against the model, biased toward valid steps so lock is reached often.
    modelCheck("rnd_rst", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      k = int'($urandom_range(0, 99));
      u = 8'($urandom) & 8'hC0;
      if (k < 75)      u = u | 8'((mPrev + 1) % 16);
      else if (k < 83) u = u | 8'h10;
      else if (k < 93) u = u | (8'($urandom) & 8'h1F);
      else if (k < 97) u = u | 8'h20 | (8'($urandom) & 8'h1F);
      else             u = 8'($urandom);
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 9) != 0);
      modelCheck("rnd", r, e, u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
